// File: rtl/mem_arbiter.sv
// Byte-serial RAM arbiter: load/store path has priority over instruction fetch.
// Optional MEMCTRL_IO_STALL_EN holds store beats to the IO window while the UART buffer is full.
module mem_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int IF_LINE_WORDS = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        clear,
  input  logic [7:0]                  mem_din,
  output logic [7:0]                  mem_dout,
  output logic [ADDR_WIDTH-1:0]       mem_a,
  output logic                        mem_wr,
  input  logic                        io_buffer_full,
  input  logic                        if_req,
  input  logic [ADDR_WIDTH-1:0]       if_addr,
  output logic                        if_done,
  output logic [32*IF_LINE_WORDS-1:0] if_rdata,
  input  logic                        lsu_req,
  input  logic                        lsu_we,
  input  logic [1:0]                  lsu_size,
  input  logic                        lsu_signed,
  input  logic [ADDR_WIDTH-1:0]       lsu_addr,
  input  logic [31:0]                 lsu_wdata,
  output logic                        lsu_done,
  output logic [31:0]                 lsu_rdata
);
  // state | meaning
  // IDLE  | no access running; accepts lsu_req first, then if_req
  // FETCH | read burst of 4*IF_LINE_WORDS bytes for the instruction queue
  // LOAD  | read burst of 1/2/4 bytes, extended on completion
  // STORE | write burst of 1/2/4 bytes, unaffected by clear
  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;

  localparam int LINE_W = 32 * IF_LINE_WORDS;
  localparam logic [4:0] FETCH_BEATS = 5'(4 * IF_LINE_WORDS);

  state_t              state;
  logic [4:0]          beat_cnt;
  logic [4:0]          n_beats;
  logic                rd_act;
  logic                rd_vld;
  logic [3:0]          rd_idx;
  logic [LINE_W-1:0]   line_buf;
  logic [LINE_W-1:0]   line_next;
  logic [1:0]          size_q;
  logic                signed_q;
  logic [31:0]         wdata_q;
  logic                wr_q;
  logic                io_stall;
  logic                last_rd;

`ifdef MEMCTRL_IO_STALL_EN
  assign io_stall = (state == STORE) && (mem_a[17:16] == 2'b11) && io_buffer_full;
`else
  logic unused_io;
  assign unused_io = io_buffer_full;
  assign io_stall  = 1'b0;
`endif

  assign mem_wr = wr_q & rdy & ~io_stall;

  function automatic logic [4:0] beats_of(input logic [1:0] size);
    case (size)
      2'd0:    beats_of = 5'd1;
      2'd1:    beats_of = 5'd2;
      default: beats_of = 5'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] size,
                                         input logic sgn);
    case (size)
      2'd0:    extend = {{24{w[7] & sgn}}, w[7:0]};
      2'd1:    extend = {{16{w[15] & sgn}}, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  // Byte arriving on mem_din this cycle merged into the line being assembled.
  always_comb begin
    line_next = line_buf;
    line_next[{rd_idx, 3'b000} +: 8] = mem_din;
  end

  assign last_rd = rd_vld && ({1'b0, rd_idx} == n_beats - 5'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      n_beats   <= '0;
      rd_act    <= 1'b0;
      rd_vld    <= 1'b0;
      rd_idx    <= '0;
      line_buf  <= '0;
      size_q    <= '0;
      signed_q  <= 1'b0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      mem_a     <= '0;
      mem_dout  <= '0;
      if_done   <= 1'b0;
      if_rdata  <= '0;
      lsu_done  <= 1'b0;
      lsu_rdata <= '0;
    end else if (rdy) begin
      if_done  <= 1'b0;
      lsu_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!clear && lsu_req) begin
            state    <= lsu_we ? STORE : LOAD;
            mem_a    <= lsu_addr;
            n_beats  <= beats_of(lsu_size);
            beat_cnt <= 5'd1;
            size_q   <= lsu_size;
            signed_q <= lsu_signed;
            wdata_q  <= lsu_wdata;
            rd_vld   <= 1'b0;
            if (lsu_we) begin
              wr_q     <= 1'b1;
              mem_dout <= lsu_wdata[7:0];
            end else begin
              rd_act <= 1'b1;
            end
          end else if (!clear && if_req) begin
            state    <= FETCH;
            mem_a    <= if_addr;
            n_beats  <= FETCH_BEATS;
            beat_cnt <= 5'd1;
            rd_act   <= 1'b1;
            rd_vld   <= 1'b0;
          end
        end
        FETCH, LOAD: begin
          if (clear) begin
            state  <= IDLE;
            rd_act <= 1'b0;
            rd_vld <= 1'b0;
          end else begin
            // The byte addressed this cycle is on mem_din next cycle.
            rd_vld <= rd_act;
            rd_idx <= 4'(beat_cnt - 5'd1);
            if (rd_act && (beat_cnt < n_beats)) begin
              mem_a    <= mem_a + ADDR_WIDTH'(1);
              beat_cnt <= beat_cnt + 5'd1;
            end else begin
              rd_act <= 1'b0;
            end
            if (rd_vld) line_buf <= line_next;
            if (last_rd) begin
              state  <= IDLE;
              rd_vld <= 1'b0;
              if (state == FETCH) begin
                if_rdata <= line_next;
                if_done  <= 1'b1;
              end else begin
                lsu_rdata <= extend(line_next[31:0], size_q, signed_q);
                lsu_done  <= 1'b1;
              end
            end
          end
        end
        STORE: begin
          if (!io_stall) begin
            if (beat_cnt < n_beats) begin
              mem_a    <= mem_a + ADDR_WIDTH'(1);
              mem_dout <= wdata_q[{beat_cnt[1:0], 3'b000} +: 8];
              beat_cnt <= beat_cnt + 5'd1;
            end else begin
              wr_q     <= 1'b0;
              lsu_done <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 2-word fetch line and a 4 KiB byte RAM model.
// Define MEMCTRL_IO_STALL_EN for both files to include the IO stall step.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst, rdy, clear;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;
  logic        if_req, if_done;
  logic [31:0] if_addr;
  logic [63:0] if_rdata;
  logic        lsu_req, lsu_we, lsu_signed, lsu_done;
  logic [1:0]  lsu_size;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int wr_cyc[$];
  logic [31:0] wr_addr[$];
  logic [7:0]  wr_data[$];
  logic [7:0]  ram [4096];

  mem_arbiter #(.ADDR_WIDTH(32), .IF_LINE_WORDS(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_size(lsu_size), .lsu_signed(lsu_signed),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr) begin
      ram[mem_a[11:0]] <= mem_dout;
      wr_cyc.push_back(cyc);
      wr_addr.push_back(mem_a);
      wr_data.push_back(mem_dout);
    end
    mem_din <= ram[mem_a[11:0]];
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns done cycle (accept edge ends cycle 0) or -1 on timeout; t0 maps log stamps to cycles.
  task automatic run_lsu(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int clr_cyc, input int rdy_cyc, input int io_cyc,
                         output int lat, output logic [31:0] rdata, output int t0);
    @(negedge clk);
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
    lsu_we = we; lsu_size = size; lsu_signed = sgn; lsu_addr = addr; lsu_wdata = wdata;
    lsu_req = 1'b1;
    @(posedge clk); #1;
    lsu_req = 1'b0;
    t0 = cyc - 1;
    lat = -1;
    rdata = '0;
    for (int k = 1; k <= 40; k++) begin
      clear = (k == clr_cyc);
      rdy = (k != rdy_cyc);
      io_buffer_full = (k <= io_cyc);
      if (lsu_done) begin
        lat = k;
        rdata = lsu_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    clear = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
  endtask

  task automatic run_if(input logic [31:0] addr, input int clr_cyc,
                        output int lat, output logic [63:0] rdata);
    @(negedge clk);
    if_addr = addr;
    if_req = 1'b1;
    @(posedge clk); #1;
    if_req = 1'b0;
    lat = -1;
    rdata = '0;
    for (int k = 1; k <= 30; k++) begin
      clear = (k == clr_cyc);
      if (if_done && lat < 0) begin
        lat = k;
        rdata = if_rdata;
      end
      @(posedge clk); #1;
    end
    clear = 1'b0;
  endtask

  initial begin
    int lat, t0, lat2;
    logic [31:0] rd;
    logic [63:0] line;
    int both;

    rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = '0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_size = '0; lsu_signed = 1'b0;
    lsu_addr = '0; lsu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_dout", mem_dout, 0);
    chk("rst_done", {if_done, lsu_done}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_lsu_rdata", lsu_rdata, 0);
    @(negedge clk);
    rst = 1'b0;

    run_lsu(1'b1, 2'd2, 1'b0, 32'h100, 32'h12345678, 0, 0, 0, lat, rd, t0);
    chk("sw_lat", lat, 5);
    chk("sw_nwr", wr_cyc.size(), 4);
    if (wr_cyc.size() == 4) begin
      chk("sw_first", {32'(wr_cyc[0] - t0), wr_addr[0], 8'(wr_data[0])}, {32'd1, 32'h100, 8'h78});
      chk("sw_last", {32'(wr_cyc[3] - t0), wr_addr[3], 8'(wr_data[3])}, {32'd4, 32'h103, 8'h12});
    end
    chk("sw_wr_low_done", mem_wr, 0);

    run_lsu(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 0, 0, lat, rd, t0);
    chk("lw_lat", lat, 6);
    chk("lw_data", rd, 32'h12345678);

    run_lsu(1'b1, 2'd0, 1'b0, 32'h20, 32'hFFFF_FF80, 0, 0, 0, lat, rd, t0);
    chk("sb_lat", lat, 2);
    run_lsu(1'b0, 2'd0, 1'b1, 32'h20, 32'h0, 0, 0, 0, lat, rd, t0);
    chk("lb_lat", lat, 3);
    chk("lb_data", rd, 32'hFFFFFF80);
    run_lsu(1'b0, 2'd0, 1'b0, 32'h20, 32'h0, 0, 0, 0, lat, rd, t0);
    chk("lbu_lat", lat, 3);
    chk("lbu_data", rd, 32'h00000080);

    run_lsu(1'b1, 2'd1, 1'b0, 32'h2FF, 32'h0000BEEF, 0, 0, 0, lat, rd, t0);
    chk("sh_lat", lat, 3);
    chk("sh_nwr", wr_cyc.size(), 2);
    if (wr_cyc.size() == 2) begin
      chk("sh_b0", {32'(wr_cyc[0] - t0), wr_addr[0], 8'(wr_data[0])}, {32'd1, 32'h2FF, 8'hEF});
      chk("sh_b1", {32'(wr_cyc[1] - t0), wr_addr[1], 8'(wr_data[1])}, {32'd2, 32'h300, 8'hBE});
    end
    run_lsu(1'b0, 2'd1, 1'b1, 32'h2FF, 32'h0, 0, 0, 0, lat, rd, t0);
    chk("lh_lat", lat, 4);
    chk("lh_data", rd, 32'hFFFFBEEF);
    run_lsu(1'b0, 2'd1, 1'b0, 32'h2FF, 32'h0, 0, 0, 0, lat, rd, t0);
    chk("lhu_data", rd, 32'h0000BEEF);
    run_lsu(1'b0, 2'd3, 1'b1, 32'h100, 32'h0, 0, 0, 0, lat, rd, t0);
    chk("lw_size3", {32'(lat), rd}, {32'd6, 32'h12345678});

    run_lsu(1'b1, 2'd2, 1'b0, 32'h0, 32'h03020100, 0, 0, 0, lat, rd, t0);
    run_lsu(1'b1, 2'd2, 1'b0, 32'h4, 32'h07060504, 0, 0, 0, lat, rd, t0);
    run_if(32'h0, 0, lat, line);
    chk("fetch_lat", lat, 10);
    chk("fetch_data", line, 64'h07060504_03020100);

    // lsu_req and if_req together: load first, fetch accepted on the lsu_done edge.
    @(negedge clk);
    lsu_we = 1'b0; lsu_size = 2'd2; lsu_signed = 1'b0; lsu_addr = 32'h100;
    if_addr = 32'h0;
    lsu_req = 1'b1; if_req = 1'b1;
    @(posedge clk); #1;
    lsu_req = 1'b0;
    lat = -1; lat2 = -1; both = 0; line = '0; rd = '0;
    for (int k = 1; k <= 40; k++) begin
      if (lsu_done && if_done) both++;
      if (lsu_done && lat < 0) begin lat = k; rd = lsu_rdata; end
      if (if_done && lat2 < 0) begin lat2 = k; line = if_rdata; if_req = 1'b0; end
      @(posedge clk); #1;
    end
    if_req = 1'b0;
    chk("prio_lsu_lat", lat, 6);
    chk("prio_lsu_data", rd, 32'h12345678);
    chk("prio_if_lat", lat2, 16);
    chk("prio_if_data", line, 64'h07060504_03020100);
    chk("prio_no_overlap", both, 0);

    run_if(32'h0, 2, lat, line);
    chk("clear_fetch_no_done", lat, -1);

    run_lsu(1'b1, 2'd2, 1'b0, 32'h200, 32'hCAFEF00D, 2, 0, 0, lat, rd, t0);
    chk("clear_sw_lat", lat, 5);
    chk("clear_sw_nwr", wr_cyc.size(), 4);
    run_lsu(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 0, 0, 0, lat, rd, t0);
    chk("clear_sw_readback", {32'(lat), rd}, {32'd6, 32'hCAFEF00D});

    run_lsu(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 2, 0, 0, lat, rd, t0);
    chk("clear_lw_no_done", lat, -1);

    run_lsu(1'b1, 2'd2, 1'b0, 32'h400, 32'h11223344, 0, 2, 0, lat, rd, t0);
    chk("rdy_sw_lat", lat, 6);
    chk("rdy_sw_nwr", wr_cyc.size(), 4);
    if (wr_cyc.size() == 4)
      chk("rdy_sw_b1", {32'(wr_cyc[1] - t0), wr_addr[1], 8'(wr_data[1])}, {32'd3, 32'h401, 8'h33});

    run_lsu(1'b1, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0000A55A, 0, 0, 0, lat, rd, t0);
    chk("wrap_lat", lat, 3);
    chk("wrap_nwr", wr_cyc.size(), 2);
    if (wr_cyc.size() == 2)
      chk("wrap_addr", {wr_addr[0], wr_addr[1], wr_data[1]}, {32'hFFFF_FFFF, 32'h0, 8'hA5});

`ifdef MEMCTRL_IO_STALL_EN
    run_lsu(1'b1, 2'd0, 1'b0, 32'h30000, 32'h0000005A, 0, 0, 3, lat, rd, t0);
    chk("io_lat", lat, 5);
    chk("io_nwr", wr_cyc.size(), 1);
    if (wr_cyc.size() == 1)
      chk("io_wr_cyc", {32'(wr_cyc[0] - t0), wr_addr[0]}, {32'd4, 32'h30000});
`else
    run_lsu(1'b1, 2'd0, 1'b0, 32'h30000, 32'h0000005A, 0, 0, 3, lat, rd, t0);
    chk("io_ignored_lat", lat, 2);
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
